// File: rtl/video_pattern_timing_gen.sv
// Raster timing (de/hsync/vsync/ctl) plus selectable test pattern for the HDMI transmitter.
// Latency: every output is registered, one pixel_clk after the counter state it describes.
// Backpressure: none; free-running at one pixel per clock, the sink must keep up.
module video_pattern_timing_gen #(
    parameter int   H_ACTIVE   = 1280,
    parameter int   H_FRONT    = 110,
    parameter int   H_SYNC     = 40,
    parameter int   H_BACK     = 220,
    parameter int   V_ACTIVE   = 720,
    parameter int   V_FRONT    = 5,
    parameter int   V_SYNC     = 5,
    parameter int   V_BACK     = 20,
    parameter logic HSYNC_POL  = 1'b1,
    parameter logic VSYNC_POL  = 1'b1,
    parameter int   CHECK_LOG2 = 5,
    parameter int   COORD_W    = 12
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  ctl,
    output logic [7:0]  pixel_data_0,
    output logic [7:0]  pixel_data_1,
    output logic [7:0]  pixel_data_2,
    output logic        frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG   = H_ACTIVE + H_FRONT;
    localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int VS_BEG   = V_ACTIVE + V_FRONT;
    localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);

    // running holds the counters at (0,0) for the first clock after reset release,
    // so the first frame_start leaves the block on the second clock.
    logic               running;
    logic               origin_seen;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [COORD_W-1:0] bar_px;
    logic [2:0]         bar_idx;
    logic [7:0]         frame_cnt;
    logic [1:0]         shadow_mode;
    logic [23:0]        shadow_rgb;

    logic               at_origin;
    logic               h_last;
    logic               v_last;
    logic               active_c;
    logic               hs_c;
    logic               vs_c;
    logic [1:0]         eff_mode;
    logic [23:0]        eff_rgb;
    logic [7:0]         eff_frame;
    logic [7:0]         grad;
    logic [23:0]        pix_rgb;

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign h_last    = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last    = (int'(v_cnt) == V_TOTAL - 1);
    assign active_c  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hs_c      = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END);
    assign vs_c      = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END);

    // At the frame origin the shadow is being loaded this very clock, so the first
    // pixel of a frame takes the incoming selection straight through.
    assign eff_mode  = at_origin ? mode : shadow_mode;
    assign eff_rgb   = at_origin ? solid_rgb : shadow_rgb;
    assign eff_frame = (at_origin && origin_seen) ? frame_cnt + 8'd1 : frame_cnt;
    assign grad      = 8'(h_cnt) + eff_frame;
    assign ctl       = 4'b0000;

    // Pattern selection for the current counter position
    always_comb begin
        pix_rgb = 24'h000000;
        case (eff_mode)
            2'd0:    pix_rgb = eff_rgb;
            // Bar colours fall straight out of the index bits: R off for 2,3,6,7;
            // G off for 4..7; B off for odd bars.
            2'd1:    pix_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd2:    pix_rgb = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            default: pix_rgb = {grad, grad, grad};
        endcase
    end

    // Raster counters, bar tracker, frame counter and frame-boundary shadows
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            running     <= 1'b0;
            origin_seen <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_px      <= '0;
            bar_idx     <= 3'd0;
            frame_cnt   <= 8'd0;
            shadow_mode <= 2'd0;
            shadow_rgb  <= 24'h000000;
        end else if (!running) begin
            running     <= 1'b1;
            shadow_mode <= mode;
            shadow_rgb  <= solid_rgb;
        end else begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            // Bar index steps every BAR_W pixels and parks on black past the last bar
            if (h_last) begin
                bar_px  <= '0;
                bar_idx <= 3'd0;
            end else if (bar_px == BAR_LAST) begin
                bar_px <= '0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_px <= bar_px + 1'b1;
            end

            if (at_origin) begin
                shadow_mode <= mode;
                shadow_rgb  <= solid_rgb;
                origin_seen <= 1'b1;
                if (origin_seen) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // Output register stage: timing strobes and blanked pixel data
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            de           <= 1'b0;
            hsync        <= ~HSYNC_POL;
            vsync        <= ~VSYNC_POL;
            frame_start  <= 1'b0;
            pixel_data_0 <= 8'h00;
            pixel_data_1 <= 8'h00;
            pixel_data_2 <= 8'h00;
        end else begin
            de           <= running && active_c;
            hsync        <= (running && hs_c) ? HSYNC_POL : ~HSYNC_POL;
            vsync        <= (running && vs_c) ? VSYNC_POL : ~VSYNC_POL;
            frame_start  <= running && at_origin;
            if (running && active_c) begin
                pixel_data_2 <= pix_rgb[23:16];
                pixel_data_1 <= pix_rgb[15:8];
                pixel_data_0 <= pix_rgb[7:0];
            end else begin
                pixel_data_2 <= 8'h00;
                pixel_data_1 <= 8'h00;
                pixel_data_0 <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_timing_gen.sv
// Directed bench for video_pattern_timing_gen on a 24x7 raster (16 active px, 4 active lines).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the DUT free-runs.
module tb_video_pattern_timing_gen;

    localparam int HT = 24;
    localparam int FT = 168;
    localparam int NF = 257;

    logic        pixel_clk = 1'b0;
    logic        rst       = 1'b0;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [3:0]  ctl;
    logic [7:0]  pixel_data_0;
    logic [7:0]  pixel_data_1;
    logic [7:0]  pixel_data_2;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    video_pattern_timing_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4),  .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CHECK_LOG2(1), .COORD_W(12)
    ) dut (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .mode         (mode),
        .solid_rgb    (solid_rgb),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .ctl          (ctl),
        .pixel_data_0 (pixel_data_0),
        .pixel_data_1 (pixel_data_1),
        .pixel_data_2 (pixel_data_2),
        .frame_start  (frame_start)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    function automatic logic [23:0] bar_rgb(input int i);
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    initial begin
        int x, y, f;
        int de_err, hs_err, vs_err, fs_err, px_err, de_hi, fs_hi;
        logic        exp_de;
        logic [7:0]  g;
        logic [23:0] exp_rgb;
        logic [23:0] rgb;

        de_err = 0; hs_err = 0; vs_err = 0; fs_err = 0; px_err = 0; de_hi = 0; fs_hi = 0;
        mode      = 2'd0;
        solid_rgb = 24'h123456;

        repeat (3) tick();
        check("rst_de",    de, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_ctl",   ctl, 0);
        check("rst_fs",    frame_start, 0);
        check("rst_px",    {pixel_data_2, pixel_data_1, pixel_data_0}, 24'h000000);

        @(negedge pixel_clk);
        rst = 1'b1;
        tick();
        check("edge1_fs", frame_start, 0);
        check("edge1_de", de, 0);
        tick();

        // t counts samples from the first active pixel after release
        for (int t = 0; t < NF * FT; t++) begin
            if (t > 0) tick();
            x = t % HT;
            y = (t / HT) % 7;
            f = t / FT;
            rgb = {pixel_data_2, pixel_data_1, pixel_data_0};

            exp_de = (x < 16) && (y < 4);
            if (de !== exp_de) de_err++;
            if (hsync !== ((x >= 18) && (x < 21))) hs_err++;
            if (vsync !== (y == 5)) vs_err++;
            if (frame_start !== ((x == 0) && (y == 0))) fs_err++;
            if (de === 1'b1) de_hi++;
            if (frame_start === 1'b1) fs_hi++;

            if (!exp_de) begin
                exp_rgb = 24'h000000;
            end else if (f == 0) begin
                exp_rgb = 24'h123456;
            end else if (f == 1) begin
                exp_rgb = (((x >> 1) ^ (y >> 1)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            end else if (f == 2) begin
                exp_rgb = bar_rgb(x / 2);
            end else begin
                g = 8'(x + f);
                exp_rgb = {g, g, g};
            end
            if (rgb !== exp_rgb) px_err++;

            if (t == 0) begin
                check("fs_first", frame_start, 1);
                check("solid_px0", rgb, 24'h123456);
            end
            if (t == 15)  check("de_last_active", de, 1);
            if (t == 16)  check("de_first_blank", de, 0);
            if (t == 17)  check("hs_before", hsync, 0);
            if (t == 18)  check("hs_start", hsync, 1);
            if (t == 20)  check("hs_end", hsync, 1);
            if (t == 21)  check("hs_after", hsync, 0);
            if (t == 119) check("vs_before", vsync, 0);
            if (t == 120) check("vs_start", vsync, 1);
            if (t == 143) check("vs_end", vsync, 1);
            if (t == 144) check("vs_after", vsync, 0);
            if (t == 50)  check("solid_held_midframe", rgb, 24'h123456);
            if (t == FT)  check("fs_period", frame_start, 1);
            if (t == FT + 0)  check("chk_x0y0", rgb, 24'h000000);
            if (t == FT + 2)  check("chk_x2y0", rgb, 24'hFFFFFF);
            if (t == FT + 48) check("chk_x0y2", rgb, 24'hFFFFFF);
            if (t == FT + 50) check("chk_x2y2", rgb, 24'h000000);
            if (t == 2*FT + 0)  check("bar_white", rgb, 24'hFFFFFF);
            if (t == 2*FT + 3)  check("bar_yellow", rgb, 24'hFFFF00);
            if (t == 2*FT + 4)  check("bar_cyan", rgb, 24'h00FFFF);
            if (t == 2*FT + 10) check("bar_red", rgb, 24'hFF0000);
            if (t == 2*FT + 15) check("bar_black", rgb, 24'h000000);
            if (t == 3*FT + 5)   check("grad_f3_x5", rgb, 24'h080808);
            if (t == 255*FT + 1) check("grad_wrap_f255_x1", rgb, 24'h000000);
            if (t == 256*FT + 1) check("grad_f256_x1", rgb, 24'h010101);

            // Mid-frame selection changes must wait for the next frame origin
            if (t == 30) begin
                mode      = 2'd2;
                solid_rgb = 24'hABCDEF;
            end
            if (t == FT + 30)   mode = 2'd1;
            if (t == 2*FT + 30) mode = 2'd3;
        end

        check("de_pattern",    de_err, 0);
        check("hsync_pattern", hs_err, 0);
        check("vsync_pattern", vs_err, 0);
        check("fs_pattern",    fs_err, 0);
        check("pixel_pattern", px_err, 0);
        check("de_hi_count",   de_hi, NF * 64);
        check("fs_count",      fs_hi, NF);

        // Frame 257, x=5: frame counter has wrapped to 1, so 5+1
        repeat (6) tick();
        check("pre_rst_de", de, 1);
        check("pre_rst_px", {pixel_data_2, pixel_data_1, pixel_data_0}, 24'h060606);
        #2 rst = 1'b0;
        #1;
        check("midline_rst_de", de, 0);
        check("midline_rst_px", {pixel_data_2, pixel_data_1, pixel_data_0}, 24'h000000);
        check("midline_rst_hs", hsync, 0);
        check("midline_rst_fs", frame_start, 0);

        repeat (2) tick();
        @(negedge pixel_clk);
        rst = 1'b1;
        tick();
        check("rerel_edge1_fs", frame_start, 0);
        tick();
        check("rerel_fs", frame_start, 1);
        check("rerel_grad_x0", {pixel_data_2, pixel_data_1, pixel_data_0}, 24'h000000);
        repeat (5) tick();
        check("rerel_grad_x5", {pixel_data_2, pixel_data_1, pixel_data_0}, 24'h050505);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_pattern_timing_gen.md
Name: video_pattern_timing_gen

Overview:
Parametrised successor to the fixed-format video format encoder. Generates the full raster timing for the HDMI transmitter from elaboration-time parameters: de, hsync, vsync, ctl. Also generates a runtime-selectable test pattern: solid colour, colour bars, checkerboard, or a scrolling gradient. Sits in the pixel_clk domain between the PLL and hdmi_transmitter. Mode and colour changes take effect only at frame boundaries.

Parameters:
H_ACTIVE, 1280, active pixels per line (>=8)
H_FRONT, 110, horizontal front porch pixels
H_SYNC, 40, hsync width pixels
H_BACK, 220, horizontal back porch pixels
V_ACTIVE, 720, active lines
V_FRONT, 5, vertical front porch lines
V_SYNC, 5, vsync width lines
V_BACK, 20, vertical back porch lines
HSYNC_POL, 1, asserted level of hsync
VSYNC_POL, 1, asserted level of vsync
CHECK_LOG2, 5, log2 of checkerboard square size in pixels
COORD_W, 12, width of h/v counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
pixel_clk  input  1  pixel clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
mode  input  2  0 solid, 1 colour bars, 2 checkerboard, 3 scrolling gradient
solid_rgb  input  24  solid colour {R,G,B}, used in mode 0
de  output  1  data enable
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
ctl  output  4  control bits, constant 0
pixel_data_0  output  8  blue
pixel_data_1  output  8  green
pixel_data_2  output  8  red
frame_start  output  1  one-cycle pulse, coincident with the first active pixel of each frame

Behaviour:
- H_TOTAL = sum of the H_* timing parameters; V_TOTAL = sum of the V_* timing parameters.
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps and wraps at V_TOTAL-1.
- Line order is active, front porch, sync, back porch. Frame order is the same.
- All outputs are registered. Each output at cycle n reflects the counter state at cycle n-1, so latency is 1 cycle. Pattern data is aligned with de.
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync = HSYNC_POL when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC; otherwise ~HSYNC_POL.
- vsync = VSYNC_POL for whole lines where V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC; otherwise ~VSYNC_POL.
- frame_start = registered (h_cnt==0 && v_cnt==0).
- Frame-boundary latch: mode and solid_rgb are sampled into shadow registers on the cycle the counters are at (0,0). The pattern uses only the shadow values; a mid-frame change is ignored until the next frame.
- frame_cnt (8 bit) increments at each (0,0) after the first and wraps 255->0.
- Whenever de would be 0, all pixel_data outputs are 0.
- Mode 0 (solid): R,G,B = shadow solid_rgb.
- Mode 1 (colour bars): BAR_W = H_ACTIVE/8, integer, computed at elaboration.
  - A bar pixel counter and a 3-bit bar index reset at h_cnt==0. No divider.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Components are FF or 00.
  - Remainder pixels beyond 8*BAR_W stay in bar 7 (black).
- Mode 2 (checkerboard): white (FF,FF,FF) if h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2] is 1, else black.
- Mode 3 (scrolling gradient): R=G=B = (h_cnt[7:0] + frame_cnt) mod 256.
- Reset (async assert, synchronous release), regardless of mid-frame state:
  - counters, frame_cnt and shadows go to 0 (shadow mode 0, shadow colour 000000).
  - de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, ctl=0, pixel_data=0, frame_start=0.
- After release: counters sit at (0,0) on the first clock, and shadows latch the inputs on that clock. frame_start=1 and the first pixel appear on the output one clock later.

Test Plan:
Small parameters: H 16/2/3/3 (H_TOTAL=24), V 4/1/1/1 (V_TOTAL=7), CHECK_LOG2=1, polarities 1.
1. Reset -> hsync=0, vsync=0, de=0, data 0. Release -> frame_start=1 on the 2nd edge, then de=1 for 16 cycles, then 8 cycles de=0.
2. Free-run -> hsync high at h_cnt 18..20, period 24. de high 64 cycles per frame. frame_start period 168 cycles.
3. vsync -> high exactly for line 5 (24 cycles), starting at the line's first pixel slot.
4. mode=1 -> BAR_W=2: x0-1 = FF/FF/FF, x2-3 = R FF G FF B 00, x4-5 = 00/FF/FF, ..., x14-15 = 00/00/00.
5. mode switched from 0 to 2 mid-frame -> solid continues until the next frame_start. Then x0-1,y0 = black, x2-3,y0 = white, x0,y2 = white.
6. mode=3 -> frame 0 x=5 gives 05 on all channels, frame 1 gives 06. Frame 255 x=1 gives 00 (wrap). rst asserted mid-line -> outputs return to reset values immediately.
